bubble_sort4_stream: RTL and testbench

BUBBLE_SORT4_STREAM -- requirements
Module: bubble_sort4_stream

---
 rtl/bubble_sort4_stream.sv | 110 +++++++++++
 tb/tb_bubble_sort4_stream.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bubble_sort4_stream.sv
// Streaming 4-element sorter: load four elements, sort in six compare-swap cycles, emit in order.
// Define BUBBLE_SORT4_DESCEND_EN for descending output; the default build sorts ascending.
module bubble_sort4_stream #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {LOAD, SORT, EMIT} state_t;

    state_t       state;
    logic [W-1:0] v [4];
    logic [1:0]   idx;
    logic [2:0]   step;
    logic [1:0]   lo;
    logic [1:0]   hi;
    logic         swap;

    // Pair order (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) for steps 0..5.
    always_comb begin
        lo = 2'd0;
        case (step)
            3'd1, 3'd4: lo = 2'd1;
            3'd2:       lo = 2'd2;
            default:    lo = 2'd0;
        endcase
        hi = lo + 2'd1;
`ifdef BUBBLE_SORT4_DESCEND_EN
        swap = v[lo] < v[hi];
`else
        swap = v[lo] > v[hi];
`endif
    end

    assign out_data = v[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            step      <= '0;
            for (int unsigned i = 0; i < 4; i++) v[i] <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        v[idx] <= in_data;
                        if (idx == 2'd3) begin
                            state    <= SORT;
                            idx      <= '0;
                            step     <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                SORT: begin
                    if (swap) begin
                        v[lo] <= v[hi];
                        v[hi] <= v[lo];
                    end
                    if (step == 3'd5) begin
                        state     <= EMIT;
                        step      <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (idx == 2'd3) begin
                            state     <= LOAD;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            idx      <= idx + 2'd1;
                            out_last <= (idx == 2'd2);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort4_stream.sv
// Randomized bench for bubble_sort4_stream; expected order comes from a queue sort of each burst.
module tb_bubble_sort4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    bubble_sort4_stream #(.W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load one burst with the given idle gaps, then verify the six SORT cycles and the latency.
    task automatic send(input int d[4], input int g[4]);
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
`ifdef BUBBLE_SORT4_DESCEND_EN
        exp_q.rsort();
`else
        exp_q.sort();
`endif
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < g[i]; j++) begin
                check("ld_ready", in_ready, 1);
                in_valid = 1'b0; in_data = 4'($urandom); out_ready = 1'($urandom);
                @(negedge clk);
            end
            check("ld_ready", in_ready, 1);
            check("ld_valid", out_valid, 0);
            in_valid = 1'b1; in_data = 4'(d[i]); out_ready = 1'($urandom);
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            check("sort_valid", out_valid, 0);
            check("sort_ready", in_ready, 0);
            check("sort_busy", busy, 1);
            in_valid = 1'($urandom); in_data = 4'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
        end
        check("latency", out_valid, 1);
    endtask

    task automatic recv(input int stall_at, input int stall_n, input bit rnd);
        int n = 0;
        int stalls = 0;
        int cyc = 0;
        while (n < 4 && cyc < 200) begin
            check("em_valid", out_valid, 1);
            check("em_ready", in_ready, 0);
            check("em_busy", busy, 1);
            check("em_data", out_data, exp_q[n]);
            check("em_last", out_last, (n == 3));
            in_valid = 1'($urandom); in_data = 4'($urandom);
            if (n == stall_at && stalls < stall_n) begin
                out_ready = 1'b0;
                stalls++;
            end else if (rnd) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready) n++;
            @(negedge clk);
            cyc++;
        end
        check("em_count", n, 4);
        check("done_ready", in_ready, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 0);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int d[4];
        int g[4];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        send('{9, 3, 7, 1}, '{0, 0, 0, 0}); recv(-1, 0, 1'b0);
        send('{5, 5, 2, 5}, '{0, 0, 0, 0}); recv(1, 3, 1'b0);
        send('{15, 0, 8, 10}, '{0, 1, 2, 0}); recv(-1, 0, 1'b0);

        // Reset during the third SORT cycle must drop the burst entirely.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'(4 - i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy1", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            check("mid_rst_quiet", out_valid, 0);
            @(negedge clk);
        end
        send('{6, 14, 1, 0}, '{0, 0, 0, 0}); recv(-1, 0, 1'b1);

        send('{3, 2, 1, 0}, '{0, 0, 0, 0}); recv(-1, 0, 1'b0);
        send('{0, 1, 2, 3}, '{0, 0, 0, 0}); recv(-1, 0, 1'b0);

        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < 4; i++) begin
                d[i] = $urandom_range(0, 15);
                g[i] = $urandom_range(0, 2);
            end
            send(d, g);
            recv(-1, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
